// File: rtl/result_serializer_if.sv
// Handshake/bus bundle between the control block, the result serializer and its consumer.
// With RESULT_SERIALIZER_PARITY_EN defined the bundle also carries out_parity.
interface result_serializer_if #(
  parameter int WORD_LENGHT = 16,
  parameter int LANES       = 8
);
  logic                          load;
  logic [3:0]                    N;
  logic [LANES*WORD_LENGHT-1:0]  lane_data;
  logic                          out_ready;
  logic [WORD_LENGHT-1:0]        out_data;
  logic                          out_valid;
  logic                          out_last;
  logic                          busy;
  logic                          overrun;
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic                          out_parity;
`endif

  modport master (
    output load, N, lane_data, out_ready,
    input  out_data, out_valid, out_last, busy, overrun
`ifdef RESULT_SERIALIZER_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  load, N, lane_data, out_ready,
    output out_data, out_valid, out_last, busy, overrun
`ifdef RESULT_SERIALIZER_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/result_serializer.sv
// Captures up to LANES parallel results on load and streams them lane 0 first over valid/ready.
// Optional even-parity output enabled by defining RESULT_SERIALIZER_PARITY_EN.
module result_serializer #(
  parameter int WORD_LENGHT = 16,
  parameter int LANES       = 8
) (
  input logic                clk,
  input logic                reset,
  result_serializer_if.slave bus
);
  localparam int          IW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [3:0]  LANES_CNT = 4'(LANES);
  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_SEND    = 1'b1;

  logic [WORD_LENGHT-1:0] w_lane [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = bus.lane_data[gi*WORD_LENGHT +: WORD_LENGHT];
    end
  endgenerate

  logic [0:0]             r_state;
  logic [IW-1:0]          r_index;
  logic [3:0]             r_count;
  logic [WORD_LENGHT-1:0] r_buf [LANES];
  logic [WORD_LENGHT-1:0] r_data;
  logic                   r_last;
  logic                   r_overrun;

  logic                   w_send;
  logic                   w_load_req;
  logic                   w_xfer;
  logic                   w_final;
  logic                   w_accept;
  logic                   w_drop;
  logic [3:0]             w_n_clamped;
  logic [IW-1:0]          w_index_inc;
  logic                   w_last_inc;

  assign w_send      = (r_state == S_SEND);
  assign w_load_req  = bus.load && (bus.N != 4'd0);
  assign w_xfer      = w_send && bus.out_ready;
  assign w_final     = w_xfer && r_last;
  // A load landing on the final transfer restarts the stream with no bubble.
  assign w_accept    = w_load_req && (!w_send || w_final);
  assign w_drop      = w_load_req && w_send && !w_final;
  assign w_n_clamped = (bus.N > LANES_CNT) ? LANES_CNT : bus.N;
  assign w_index_inc = r_index + IW'(1);
  assign w_last_inc  = (4'(w_index_inc) == (r_count - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_index   <= '0;
      r_count   <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < LANES; i++) r_buf[i] <= w_lane[i];
        r_count <= w_n_clamped;
        r_index <= '0;
        r_data  <= w_lane[0];
        r_last  <= (w_n_clamped == 4'd1);
        r_state <= S_SEND;
      end else if (w_final) begin
        r_state <= S_IDLE;
        r_index <= '0;
        r_data  <= '0;
        r_last  <= 1'b0;
      end else if (w_xfer) begin
        r_index <= w_index_inc;
        r_data  <= r_buf[w_index_inc];
        r_last  <= w_last_inc;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = w_send;
  assign bus.out_last  = r_last;
  assign bus.busy      = w_send;
  assign bus.overrun   = r_overrun;

`ifdef RESULT_SERIALIZER_PARITY_EN
  logic r_parity;

  // Parity tracks the word being loaded into r_data, so it is registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^w_lane[0];
    end else if (w_final) begin
      r_parity <= 1'b0;
    end else if (w_xfer) begin
      r_parity <= ^r_buf[w_index_inc];
    end
  end

  assign bus.out_parity = r_parity;
`endif
endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_result_serializer;
  localparam int W = 16;
  localparam int L = 8;

  logic clk;
  logic reset;

  result_serializer_if #(.WORD_LENGHT(W), .LANES(L)) bus ();

  result_serializer #(.WORD_LENGHT(W), .LANES(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [L*W-1:0] ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Monitor: pops on every transfer, checks holding under backpressure and idle-output rules.
  logic         held;
  logic [W-1:0] held_data;
  logic         held_last;
  initial held = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", {16'd0, bus.out_data}, {16'd0, held_data});
        chk("hold_last", {31'd0, bus.out_last}, {31'd0, held_last});
      end
      if (!bus.out_valid) begin
        chk("idle_last", {31'd0, bus.out_last}, 32'd0);
      end
`ifdef RESULT_SERIALIZER_PARITY_EN
      chk("parity", {31'd0, bus.out_parity}, {31'd0, bus.out_valid ? ^bus.out_data : 1'b0});
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'd0, bus.out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", {16'd0, bus.out_data}, {16'd0, e.data});
          chk("word_last", {31'd0, bus.out_last}, {31'd0, e.last});
          $display("xfer data=%h last=%0d", bus.out_data, bus.out_last);
        end
      end
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_last = bus.out_last;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.load      = 1'b0;
    bus.N         = 4'd0;
    bus.lane_data = '0;
    bus.out_ready = 1'b0;
    tick();
    do_reset();

    // Reset values
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_last", {31'd0, bus.out_last}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_data", {16'd0, bus.out_data}, 32'd0);

    // N==0 load is ignored
    bus.lane_data = {8{16'hBEEF}};
    bus.load = 1'b1; bus.N = 4'd0;
    tick();
    bus.load = 1'b0;
    tick();
    chk("n0_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("n0_overrun", {31'd0, bus.overrun}, 32'd0);

    // Basic stream, N=4
    for (int i = 0; i < L; i++) ld[i*W +: W] = 16'h1111 * 16'(i);
    bus.lane_data = ld; bus.N = 4'd4; bus.load = 1'b1; bus.out_ready = 1'b1;
    push(16'h0000, 1'b0); push(16'h1111, 1'b0); push(16'h2222, 1'b0); push(16'h3333, 1'b1);
    tick();
    bus.load = 1'b0;
    chk("basic_busy_start", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("basic_drained", exp_q.size(), 32'd0);
    chk("basic_busy_end", {31'd0, bus.busy}, 32'd0);

    // Backpressure, N=3, ready 1,0,0,1,1
    for (int i = 0; i < L; i++) ld[i*W +: W] = 16'h5A00 + 16'(i);
    bus.lane_data = ld; bus.N = 4'd3; bus.load = 1'b1; bus.out_ready = 1'b1;
    push(16'h5A00, 1'b0); push(16'h5A01, 1'b0); push(16'h5A02, 1'b1);
    tick();
    bus.load = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    tick();
    tick();
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("bp_drained", exp_q.size(), 32'd0);
    chk("bp_busy_end", {31'd0, bus.busy}, 32'd0);

    // Clamp N=15 to 8 words, with a dropped load mid-stream
    for (int i = 0; i < L; i++) ld[i*W +: W] = 16'hA000 + 16'(i);
    bus.lane_data = ld; bus.N = 4'd15; bus.load = 1'b1;
    for (int i = 0; i < L; i++) push(16'hA000 + 16'(i), (i == L-1));
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    bus.lane_data = {8{16'hDEAD}}; bus.N = 4'd3; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("drop_overrun", {31'd0, bus.overrun}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("clamp_drained", exp_q.size(), 32'd0);
    chk("clamp_busy_end", {31'd0, bus.busy}, 32'd0);
    tick(); tick(); tick();
    chk("overrun_sticky", {31'd0, bus.overrun}, 32'd1);

    // Back-to-back: N=4 then N=2 on the final transfer
    do_reset();
    chk("rst_clears_overrun", {31'd0, bus.overrun}, 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < L; i++) ld[i*W +: W] = 16'h1000 + 16'(i);
    bus.lane_data = ld; bus.N = 4'd4; bus.load = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i), (i == 3));
    tick();
    bus.load = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < L; i++) ld[i*W +: W] = 16'h2000 + 16'(i);
    bus.lane_data = ld; bus.N = 4'd2; bus.load = 1'b1;
    push(16'h2000, 1'b0); push(16'h2001, 1'b1);
    tick();
    bus.load = 1'b0;
    tick(); tick();
    chk("b2b_drained", exp_q.size(), 32'd0);
    chk("b2b_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("b2b_overrun", {31'd0, bus.overrun}, 32'd0);

    // Reset mid-stream after 2 of 5 words, with a load held during reset
    for (int i = 0; i < L; i++) ld[i*W +: W] = 16'hC000 + 16'(i);
    bus.lane_data = ld; bus.N = 4'd5; bus.load = 1'b1;
    push(16'hC000, 1'b0); push(16'hC001, 1'b0);
    tick();
    bus.load = 1'b0;
    tick(); tick();
    bus.out_ready = 1'b0; reset = 1'b1; bus.load = 1'b1; bus.N = 4'd3;
    tick();
    reset = 1'b0; bus.load = 1'b0;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_queue", exp_q.size(), 32'd0);
    tick();
    chk("rst_load_ignored", {31'd0, bus.out_valid}, 32'd0);
    bus.lane_data = {8{16'h7E5D}}; bus.N = 4'd1; bus.load = 1'b1; bus.out_ready = 1'b1;
    push(16'h7E5D, 1'b1);
    tick();
    bus.load = 1'b0;
    tick();
    chk("single_drained", exp_q.size(), 32'd0);
    chk("single_busy_end", {31'd0, bus.busy}, 32'd0);

    tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
